adc_capture_ctrl: RTL and testbench
===================================

ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, capture buffer address width (depth 2^ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 12, per-channel ADC sample width.
REQ-003 SHALL have ports:
- sys_clk  in  1  sole clock; ADC sample rate, one sample pair per rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- ad_data_ch0  in  DATA_W  channel 0 sample, unsigned offset-binary.
- ad_data_ch1  in  DATA_W  channel 1 sample, unsigned offset-binary.
- arm  in  1  single-cycle pulse; start a capture sequence.
- abort  in  1  single-cycle pulse; cancel any sequence.
- trig_mode  in  2  0 immediate, 1 ch0 rising level crossing, 2 ext_trig rising edge, 3 reserved (treated as 0).
- trig_level  in  DATA_W  crossing threshold for mode 1.
- ext_trig  in  1  external trigger, synchronous to sys_clk.
- decim  in  8  keep 1 of every decim+1 samples.
- capture_len  in  ADDR_W+1  samples to store; 0 means 2^ADDR_W.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  ADDR_W  buffer write address.
- wr_data  out  2*DATA_W  {ch1, ch0} sample pair.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- trig_addr  out  ADDR_W  reserved for pretrigger; always 0 in this revision.

Function
REQ-004 SHALL implement FSM states IDLE, ARMED, CAPTURE, DONE.
REQ-005 SHALL register ad_data_ch0/ch1 once on entry (stage s1); all trigger and write logic SHALL use s1 and the previous s1 value (s0).
REQ-006 SHALL, on arm in IDLE or DONE, latch trig_mode, trig_level, decim, capture_len, clear done, and go to ARMED next cycle.
REQ-007 SHALL ignore arm while in ARMED or CAPTURE.
REQ-008 SHALL, in ARMED:
- mode 0/3: go to CAPTURE on the next cycle.
- mode 1: go to CAPTURE when s0 < trig_level and s1 >= trig_level (unsigned compare on ch0).
- mode 2: go to CAPTURE when ext_trig is 1 and was 0 on the previous cycle; the edge detector history SHALL be updated in all states.
REQ-009 SHALL make the triggering sample pair (s1 on the trigger cycle) the first stored sample, at wr_addr 0.
REQ-010 SHALL, in CAPTURE, run a decimation counter starting at 0 on the trigger sample; a sample is kept when the counter is 0; counter wraps from latched decim to 0; decim=0 keeps every sample.
REQ-011 SHALL assert wr_en for exactly one cycle per kept sample, with wr_data/wr_addr valid in the same cycle, exactly 1 cycle after that sample is in s1.
REQ-012 SHALL increment wr_addr after each write, starting at 0, and never exceed length-1, where length = latched capture_len, or 2^ADDR_W if 0.
REQ-013 SHALL go to DONE in the cycle the last write (address length-1) is issued; done SHALL be high from the next cycle.
REQ-014 SHALL stay in DONE until arm or abort.
REQ-015 SHALL, on abort in any state, go to IDLE next cycle, deassert wr_en that cycle, and clear done; abort SHALL win over a simultaneous arm or trigger.
REQ-016 SHALL NOT generate wr_en outside CAPTURE, except the final write of REQ-013.
REQ-017 SHALL hold wr_data and wr_addr at their last values when wr_en is low.
REQ-018 SHALL ignore input changes to latched configuration ports until the next arm.

Reset
REQ-019 SHALL, while rst_n is low, asynchronously force: state IDLE, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, trig_addr 0, s0/s1 0, decimation counter 0, ext_trig history 0.
REQ-020 SHALL release reset synchronously to sys_clk; reset mid-capture SHALL discard the sequence with no further writes.

Verification
REQ-021 Mode 0, decim 0, capture_len 4, ramp input: arm -> 4 consecutive wr_en at addr 0..3 with data matching ramp at trigger +0..3, then done=1, busy=0.
REQ-022 Mode 1, trig_level 0x800, ch0 ramp 0x7FE..0x802: arm -> first write holds ch0=0x800; no write while ch0 stays below 0x800.
REQ-023 Mode 0, decim 2, capture_len 3: -> writes of samples n, n+3, n+6 at addr 0,1,2; wr_en spacing 3 cycles.
REQ-024 capture_len 0, ADDR_W 4: -> exactly 16 writes, addr 0..15, no wrap past 15.
REQ-025 Abort during CAPTURE after 2 of 8 writes, with simultaneous arm: -> IDLE next cycle, no further wr_en, done 0, busy 0.
REQ-026 rst_n low mid-capture in mode 2: -> all outputs 0 immediately; after release, ext_trig rising edge without arm -> no wr_en.

Source files
------------

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: triggered dual-channel ADC capture sequencer.
// Samples are staged once (s1, with s0 the previous s1), a trigger is searched
// for while ARMED, and the triggering sample plus every (decim+1)-th sample after
// it are written to a capture buffer until capture_len samples are stored.
module adc_capture_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     ad_data_ch0,
  input  logic [DATA_W-1:0]     ad_data_ch1,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [1:0]            trig_mode,
  input  logic [DATA_W-1:0]     trig_level,
  input  logic                  ext_trig,
  input  logic [7:0]            decim,
  input  logic [ADDR_W:0]       capture_len,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [2*DATA_W-1:0]   wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     trig_addr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_LEN  = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q;
  logic [DATA_W-1:0]   s1_ch0_q;
  logic [DATA_W-1:0]   s1_ch1_q;
  logic [DATA_W-1:0]   s0_ch0_q;
  logic                ext_q;

  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   level_q;
  logic [7:0]          decim_q;
  logic [ADDR_W:0]     len_q;

  logic [7:0]          dcnt_q;
  logic [ADDR_W-1:0]   next_q;

  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [2*DATA_W-1:0] wr_data_q;
  logic                busy_q;
  logic                done_q;

  logic                trig_hit;
  logic                last_wr;

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign trig_addr = '0;

  // Sample staging and ext_trig edge history, updated in every state.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ch0_q <= '0;
      s1_ch1_q <= '0;
      s0_ch0_q <= '0;
      ext_q    <= 1'b0;
    end else begin
      s1_ch0_q <= ad_data_ch0;
      s1_ch1_q <= ad_data_ch1;
      s0_ch0_q <= s1_ch0_q;
      ext_q    <= ext_trig;
    end
  end

  // Trigger condition for the latched mode; reserved mode 3 behaves as immediate.
  always_comb begin
    trig_hit = 1'b1;
    case (mode_q)
      2'd1:    trig_hit = (s0_ch0_q < level_q) && (s1_ch0_q >= level_q);
      2'd2:    trig_hit = ext_trig & ~ext_q;
      default: trig_hit = 1'b1;
    endcase
    last_wr = ({1'b0, next_q} == (len_q - ONE_LEN));
  end

  // Capture sequencer with registered write strobe, address, data and status.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mode_q    <= '0;
      level_q   <= '0;
      decim_q   <= '0;
      len_q     <= '0;
      dcnt_q    <= '0;
      next_q    <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (arm) begin
              mode_q  <= trig_mode;
              level_q <= trig_level;
              decim_q <= decim;
              len_q   <= (capture_len == '0) ? FULL_LEN : capture_len;
              done_q  <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= S_ARMED;
            end else if (state_q == S_DONE) begin
              // done follows one cycle behind entry to DONE, so the final
              // write cycle itself shows busy low and done still low.
              done_q <= 1'b1;
            end
          end
          S_ARMED: begin
            if (trig_hit) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= '0;
              wr_data_q <= {s1_ch1_q, s1_ch0_q};
              next_q    <= ADDR_W'(1);
              dcnt_q    <= (decim_q == '0) ? '0 : 8'd1;
              if (len_q == ONE_LEN) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_CAPTURE;
              end
            end
          end
          S_CAPTURE: begin
            dcnt_q <= (dcnt_q == decim_q) ? '0 : dcnt_q + 8'd1;
            if (dcnt_q == '0) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= next_q;
              wr_data_q <= {s1_ch1_q, s1_ch0_q};
              next_q    <= next_q + ADDR_W'(1);
              if (last_wr) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: directed capture scenarios checked every cycle
// against a per-cycle expectation table built from the capture rules.
module tb_adc_capture_ctrl;

  localparam int AW   = 4;
  localparam int DW   = 12;
  localparam int MAXC = 600;

  logic              sys_clk;
  logic              rst_n;
  logic [DW-1:0]     ad_data_ch0;
  logic [DW-1:0]     ad_data_ch1;
  logic              arm;
  logic              abort;
  logic [1:0]        trig_mode;
  logic [DW-1:0]     trig_level;
  logic              ext_trig;
  logic [7:0]        decim;
  logic [AW:0]       capture_len;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [2*DW-1:0]   wr_data;
  logic              busy;
  logic              done;
  logic [AW-1:0]     trig_addr;

  adc_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .ad_data_ch0 (ad_data_ch0),
    .ad_data_ch1 (ad_data_ch1),
    .arm         (arm),
    .abort       (abort),
    .trig_mode   (trig_mode),
    .trig_level  (trig_level),
    .ext_trig    (ext_trig),
    .decim       (decim),
    .capture_len (capture_len),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .trig_addr   (trig_addr)
  );

  // Stimulus per cycle slot: values driven just after posedge n are seen during cycle n.
  logic [DW-1:0] ad0 [MAXC];
  logic [DW-1:0] ad1 [MAXC];
  bit            extv[MAXC];
  bit            armv[MAXC];
  bit            abv [MAXC];

  // Expected outputs during each cycle.
  bit e_we  [MAXC];
  bit e_busy[MAXC];
  bit e_done[MAXC];
  int e_addr[MAXC];
  int e_data[MAXC];

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;
  int nwr   = 0;
  bit chk_en = 0;
  int a;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp_v);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge sys_clk);
  endtask

  task automatic scramble_cfg();
    trig_mode   = 2'd1;
    trig_level  = 12'hFFF;
    decim       = 8'd7;
    capture_len = 5'd1;
  endtask

  // Model: from an arm in cycle a, find the trigger cycle t from the stimulus,
  // then sample t-1+j*(d+1) lands in the buffer at address j during cycle
  // t+1+j*(d+1). Abort in cycle ab cancels everything from ab+1 on.
  task automatic plan(input int arm_c, input int mode, input int lvl,
                      input int d, input int len, input int ab);
    int L, t, wc, ha, hd;
    L  = (len == 0) ? (1 << AW) : len;
    ha = e_addr[arm_c];
    hd = e_data[arm_c];
    for (int k = arm_c + 1; k < MAXC; k++) begin
      e_we[k] = 0; e_busy[k] = 1; e_done[k] = 0; e_addr[k] = ha; e_data[k] = hd;
    end
    t = -1;
    for (int k = arm_c + 1; k < MAXC; k++) begin
      if (ab >= 0 && k >= ab) break;
      if (mode == 1) begin
        if (int'(ad0[k-2]) < lvl && int'(ad0[k-1]) >= lvl) begin t = k; break; end
      end else if (mode == 2) begin
        if (extv[k] && !extv[k-1]) begin t = k; break; end
      end else begin
        t = k; break;
      end
    end
    if (t >= 0) begin
      for (int j = 0; j < L; j++) begin
        wc = t + 1 + j * (d + 1);
        if (wc >= MAXC || (ab >= 0 && wc > ab)) break;
        e_we[wc] = 1;
        for (int k = wc; k < MAXC; k++) begin
          e_addr[k] = j;
          e_data[k] = 32'({ad1[wc-2], ad0[wc-2]});
        end
        if (j == L - 1) begin
          for (int k = wc; k < MAXC; k++) e_busy[k] = 0;
          for (int k = wc + 1; k < MAXC; k++) e_done[k] = 1;
        end
      end
    end
    if (ab >= 0)
      for (int k = ab + 1; k < MAXC; k++) begin
        e_we[k] = 0; e_busy[k] = 0; e_done[k] = 0;
      end
  endtask

  task automatic plan_reset(input int r);
    for (int k = r; k < MAXC; k++) begin
      e_we[k] = 0; e_busy[k] = 0; e_done[k] = 0; e_addr[k] = 0; e_data[k] = 0;
    end
  endtask

  // Driver: apply this cycle's stimulus slot just after the rising edge.
  initial begin
    forever begin
      @(posedge sys_clk);
      cyc++;
      #1;
      if (cyc < MAXC) begin
        ad_data_ch0 = ad0[cyc];
        ad_data_ch1 = ad1[cyc];
        ext_trig    = extv[cyc];
        arm         = armv[cyc];
        abort       = abv[cyc];
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge sys_clk) begin
    if (chk_en && rst_n && cyc < MAXC) begin
      chk("wr_en",     32'(wr_en),     32'(e_we[cyc]));
      chk("wr_addr",   32'(wr_addr),   e_addr[cyc]);
      chk("wr_data",   32'(wr_data),   e_data[cyc]);
      chk("busy",      32'(busy),      32'(e_busy[cyc]));
      chk("done",      32'(done),      32'(e_done[cyc]));
      chk("trig_addr", 32'(trig_addr), 32'd0);
      if (wr_en) nwr++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < MAXC; k++) begin
      ad0[k] = 12'(k * 37);
      ad1[k] = 12'(k * 11 + 5);
    end
    rst_n = 1'b0;
    ad_data_ch0 = '0; ad_data_ch1 = '0; arm = 1'b0; abort = 1'b0;
    trig_mode = '0; trig_level = '0; ext_trig = 1'b0; decim = '0; capture_len = '0;
    #1;
    chk("rst_wr_en",   32'(wr_en),   32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_done",    32'(done),    32'd0);
    wait_cyc(3);
    #2 rst_n = 1'b1;
    chk_en = 1;

    // Immediate trigger, decim 0, four samples.
    a = cyc + 4;
    for (int k = a - 2; k <= a + 10; k++) begin
      ad0[k] = 12'(12'h100 + (k - a));
      ad1[k] = 12'(12'h900 + (k - a));
    end
    armv[a] = 1;
    trig_mode = 2'd0; trig_level = 12'h000; decim = 8'd0; capture_len = 5'd4;
    plan(a, 0, 0, 0, 4, -1);
    nwr = 0;
    wait_cyc(a + 2);
    scramble_cfg();
    chk("A_first_we",   32'(wr_en),   32'd1);
    chk("A_first_data", 32'(wr_data), 32'h900100);
    wait_cyc(a + 6);
    chk("A_done",      32'(done),    32'd1);
    chk("A_busy",      32'(busy),    32'd0);
    chk("A_last_addr", 32'(wr_addr), 32'd3);
    chk("A_last_data", 32'(wr_data), 32'h903103);
    wait_cyc(a + 10);
    chk("A_nwr", nwr, 32'd4);

    // Level crossing on ch0 at 0x800, decim 1, five samples.
    a = cyc + 4;
    for (int k = a - 2; k <= a + 3; k++) ad0[k] = 12'h7FE;
    ad0[a + 4] = 12'h7FF;
    for (int k = a + 5; k <= a + 25; k++) ad0[k] = 12'(12'h800 + (k - a - 5));
    for (int k = a - 2; k <= a + 25; k++) ad1[k] = 12'(12'h0A0 + (k - a));
    armv[a] = 1;
    trig_mode = 2'd1; trig_level = 12'h800; decim = 8'd1; capture_len = 5'd5;
    plan(a, 1, 'h800, 1, 5, -1);
    nwr = 0;
    wait_cyc(a + 6);
    chk("B_no_early_wr", nwr, 32'd0);
    wait_cyc(a + 7);
    chk("B_first_ch0",  32'(wr_data[DW-1:0]), 32'h800);
    chk("B_first_data", 32'(wr_data), 32'h0A5800);
    wait_cyc(a + 9);
    chk("B_second_addr", 32'(wr_addr), 32'd1);
    chk("B_second_ch0",  32'(wr_data[DW-1:0]), 32'h802);
    wait_cyc(a + 20);
    chk("B_nwr",  nwr, 32'd5);
    chk("B_done", 32'(done), 32'd1);

    // Decimation by 3, three samples, with an ignored arm mid-capture.
    a = cyc + 4;
    for (int k = a - 2; k <= a + 10; k++) begin
      ad0[k] = 12'(12'h200 + (k - a));
      ad1[k] = 12'(12'h300 + (k - a));
    end
    armv[a] = 1;
    armv[a + 4] = 1;
    trig_mode = 2'd0; decim = 8'd2; capture_len = 5'd3;
    plan(a, 0, 0, 2, 3, -1);
    nwr = 0;
    wait_cyc(a + 2);
    scramble_cfg();
    wait_cyc(a + 3);
    chk("C_gap1", 32'(wr_en), 32'd0);
    wait_cyc(a + 4);
    chk("C_gap2", 32'(wr_en), 32'd0);
    wait_cyc(a + 5);
    chk("C_second_we",   32'(wr_en),   32'd1);
    chk("C_second_addr", 32'(wr_addr), 32'd1);
    chk("C_second_data", 32'(wr_data), 32'h303203);
    wait_cyc(a + 8);
    chk("C_third_data", 32'(wr_data), 32'h306206);
    wait_cyc(a + 12);
    chk("C_nwr", nwr, 32'd3);

    // Reserved mode, capture_len 0: full 16-entry buffer without wrap.
    a = cyc + 4;
    armv[a] = 1;
    trig_mode = 2'd3; decim = 8'd0; capture_len = 5'd0;
    plan(a, 3, 0, 0, 0, -1);
    nwr = 0;
    wait_cyc(a + 3);
    scramble_cfg();
    wait_cyc(a + 17);
    chk("D_last_we",   32'(wr_en),   32'd1);
    chk("D_last_addr", 32'(wr_addr), 32'd15);
    wait_cyc(a + 19);
    chk("D_nwr",       nwr, 32'd16);
    chk("D_hold_addr", 32'(wr_addr), 32'd15);
    chk("D_done",      32'(done), 32'd1);

    // External edge trigger, single-sample capture.
    a = cyc + 4;
    for (int k = a - 2; k <= a; k++) extv[k] = 1;
    for (int k = a + 1; k <= a + 3; k++) extv[k] = 0;
    for (int k = a + 4; k <= a + 8; k++) extv[k] = 1;
    for (int k = a - 2; k <= a + 10; k++) begin
      ad0[k] = 12'(12'h400 + (k - a));
      ad1[k] = 12'(12'h500 + (k - a));
    end
    armv[a] = 1;
    trig_mode = 2'd2; decim = 8'd5; capture_len = 5'd1;
    plan(a, 2, 0, 5, 1, -1);
    nwr = 0;
    wait_cyc(a + 5);
    chk("E_we",   32'(wr_en),   32'd1);
    chk("E_data", 32'(wr_data), 32'h503403);
    wait_cyc(a + 6);
    chk("E_done", 32'(done), 32'd1);
    chk("E_busy", 32'(busy), 32'd0);
    wait_cyc(a + 12);
    chk("E_nwr", nwr, 32'd1);

    // Abort with simultaneous arm after two of eight writes.
    a = cyc + 4;
    armv[a] = 1;
    armv[a + 3] = 1;
    abv[a + 3] = 1;
    trig_mode = 2'd0; decim = 8'd0; capture_len = 5'd8;
    plan(a, 0, 0, 0, 8, a + 3);
    nwr = 0;
    wait_cyc(a + 4);
    chk("F_we",   32'(wr_en), 32'd0);
    chk("F_busy", 32'(busy),  32'd0);
    chk("F_done", 32'(done),  32'd0);
    wait_cyc(a + 14);
    chk("F_nwr", nwr, 32'd2);

    // Reset mid-capture in edge-trigger mode, then an unarmed edge.
    a = cyc + 4;
    for (int k = a - 2; k <= a + 1; k++) extv[k] = 0;
    for (int k = a + 2; k <= a + 4; k++) extv[k] = 1;
    for (int k = a + 5; k <= a + 9; k++) extv[k] = 0;
    for (int k = a + 10; k <= a + 14; k++) extv[k] = 1;
    for (int k = a + 15; k <= a + 22; k++) extv[k] = 0;
    armv[a] = 1;
    trig_mode = 2'd2; decim = 8'd0; capture_len = 5'd8;
    plan(a, 2, 0, 0, 8, -1);
    nwr = 0;
    wait_cyc(a + 5);
    #2 rst_n = 1'b0;
    #1;
    chk("G_rst_we",   32'(wr_en),     32'd0);
    chk("G_rst_addr", 32'(wr_addr),   32'd0);
    chk("G_rst_data", 32'(wr_data),   32'd0);
    chk("G_rst_busy", 32'(busy),      32'd0);
    chk("G_rst_done", 32'(done),      32'd0);
    chk("G_rst_taddr",32'(trig_addr), 32'd0);
    plan_reset(a + 6);
    nwr = 0;
    wait_cyc(a + 7);
    #2 rst_n = 1'b1;
    wait_cyc(a + 20);
    chk("G_nwr",  nwr, 32'd0);
    chk("G_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
